// File: rtl/poly_basemul_sched_pkg.sv
// Shared constants and FSM encoding for the Kyber pointwise-multiply scheduler.
package poly_basemul_sched_pkg;

    localparam int KYBER_N   = 256;
    localparam int KYBER_Q   = 3329;
    localparam int COEFF_W   = 16;
    localparam int ZETA_BASE = 64;
    localparam int ZETA_AW   = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_MUL,
        S_MUL_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

endpackage

// File: rtl/poly_basemul_sched.sv
// Walks KYBER_N/2 coefficient pairs: read, issue to an external Basemul unit, write back.
// Define BASEMUL_ACC_EN to add rd_c0/rd_c1 and accumulate them into the result (polyvec sum).
module poly_basemul_sched #(
    parameter int KYBER_N = poly_basemul_sched_pkg::KYBER_N,
    parameter int COEFF_W = poly_basemul_sched_pkg::COEFF_W,
    parameter int PAIR_AW = 7
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      rd_en,
    output logic [PAIR_AW-1:0]                        rd_addr,
    output logic [poly_basemul_sched_pkg::ZETA_AW-1:0] zeta_addr,
    input  logic                                      rd_valid,
    input  logic [COEFF_W-1:0]                        rd_a0,
    input  logic [COEFF_W-1:0]                        rd_a1,
    input  logic [COEFF_W-1:0]                        rd_b0,
    input  logic [COEFF_W-1:0]                        rd_b1,
    input  logic [COEFF_W-1:0]                        rd_zeta,
`ifdef BASEMUL_ACC_EN
    input  logic [COEFF_W-1:0]                        rd_c0,
    input  logic [COEFF_W-1:0]                        rd_c1,
`endif
    output logic                                      bm_enable,
    output logic [COEFF_W-1:0]                        bm_a0,
    output logic [COEFF_W-1:0]                        bm_a1,
    output logic [COEFF_W-1:0]                        bm_b0,
    output logic [COEFF_W-1:0]                        bm_b1,
    output logic [COEFF_W-1:0]                        bm_zeta,
    input  logic                                      bm_done,
    input  logic [COEFF_W-1:0]                        bm_r0,
    input  logic [COEFF_W-1:0]                        bm_r1,
    output logic                                      wr_en,
    output logic [PAIR_AW-1:0]                        wr_addr,
    output logic [COEFF_W-1:0]                        wr_r0,
    output logic [COEFF_W-1:0]                        wr_r1
);
    import poly_basemul_sched_pkg::*;

    state_t               r_state;
    state_t               w_next_state;
    logic [PAIR_AW-1:0]   r_pair;
    logic [COEFF_W-1:0]   r_a0, r_a1, r_b0, r_b1, r_zeta;
    logic [COEFF_W-1:0]   r_res0, r_res1;
    logic                 w_last_pair;

    assign w_last_pair = (r_pair == PAIR_AW'(KYBER_N / 2 - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (start)    w_next_state = S_RD_REQ;
            S_RD_REQ:                 w_next_state = S_RD_WAIT;
            S_RD_WAIT:  if (rd_valid) w_next_state = S_MUL;
            S_MUL:                    w_next_state = S_MUL_WAIT;
            S_MUL_WAIT: if (bm_done)  w_next_state = S_WRITE;
            S_WRITE:    w_next_state = w_last_pair ? S_FIN : S_RD_REQ;
            S_FIN:                    w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

`ifdef BASEMUL_ACC_EN
    logic [COEFF_W-1:0] r_c0, r_c1;
`endif

    // Datapath registers are reset because they drive the outputs directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pair <= '0;
            r_a0   <= '0;
            r_a1   <= '0;
            r_b0   <= '0;
            r_b1   <= '0;
            r_zeta <= '0;
            r_res0 <= '0;
            r_res1 <= '0;
`ifdef BASEMUL_ACC_EN
            r_c0   <= '0;
            r_c1   <= '0;
`endif
        end else begin
            if (r_state == S_IDLE && start)
                r_pair <= '0;
            if (r_state == S_WRITE && !w_last_pair)
                r_pair <= r_pair + 1'b1;
            if (r_state == S_RD_WAIT && rd_valid) begin
                r_a0   <= rd_a0;
                r_a1   <= rd_a1;
                r_b0   <= rd_b0;
                r_b1   <= rd_b1;
                r_zeta <= rd_zeta;
`ifdef BASEMUL_ACC_EN
                r_c0   <= rd_c0;
                r_c1   <= rd_c1;
`endif
            end
            if (r_state == S_MUL_WAIT && bm_done) begin
`ifdef BASEMUL_ACC_EN
                r_res0 <= r_c0 + bm_r0;
                r_res1 <= r_c1 + bm_r1;
`else
                r_res0 <= bm_r0;
                r_res1 <= bm_r1;
`endif
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign rd_en     = (r_state == S_RD_REQ);
    assign bm_enable = (r_state == S_MUL);
    assign wr_en     = (r_state == S_WRITE);
    assign rd_addr   = r_pair;
    assign wr_addr   = r_pair;
    // Odd pairs of a zeta block use the negated twiddle.
    assign zeta_addr = rd_en ? ZETA_AW'(ZETA_BASE) + ZETA_AW'(r_pair >> 1) : '0;
    assign bm_a0     = r_a0;
    assign bm_a1     = r_a1;
    assign bm_b0     = r_b0;
    assign bm_b1     = r_b1;
    assign bm_zeta   = r_pair[0] ? COEFF_W'(0) - r_zeta : r_zeta;
    assign wr_r0     = r_res0;
    assign wr_r1     = r_res1;

endmodule
